lsu_unit: RTL and testbench

- Load/store unit in the execute-to-writeback path, directly downstream of the ALU. It takes the ALU-computed effective address plus the rs2 store data.
- It performs one data-memory transaction over a req/ack bus, handles byte, halfword and word alignment and sign extension, and delivers load results to writeback.
- Misaligned accesses are trapped without touching the bus.

---
 rtl/lsu_unit.sv | 182 ++++++++++++++++++
 tb/tb_lsu_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_unit.sv
// Load/store unit: one req/ack data-memory transaction per op, with alignment, byte lanes and
// load extension. Optional ack timeout with bus_err output when LSU_TIMEOUT_EN is defined.
module lsu_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMEOUT_W      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_is_load,
  input  logic        ex_is_store,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign,
  output logic [31:0] fault_addr
`ifdef LSU_TIMEOUT_EN
  ,
  output logic        bus_err
`endif
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e      state_q;
  logic        is_load_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [4:0]  rd_q;

  // Counter must be able to reach the limit.
  if (TIMEOUT_CYCLES >= (64'd1 << TIMEOUT_W)) begin : g_bad_cfg
    $error("TIMEOUT_W too narrow for TIMEOUT_CYCLES");
  end

  assign ex_ready = (state_q == StIdle);

  logic        dec_load, dec_store, dec_legal, dec_misalign;
  logic [3:0]  dec_be;
  logic [31:0] dec_wdata;

  always_comb begin
    dec_load  = ex_is_load;
    dec_store = ex_is_store & ~ex_is_load;
    dec_legal = 1'b0;
    if (dec_load)       dec_legal = ex_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    else if (dec_store) dec_legal = ex_funct3 inside {3'd0, 3'd1, 3'd2};
    case (ex_funct3[1:0])
      2'b00: begin
        dec_be       = 4'b0001 << ex_addr[1:0];
        dec_wdata    = {4{ex_wdata[7:0]}};
        dec_misalign = 1'b0;
      end
      2'b01: begin
        dec_be       = ex_addr[1] ? 4'b1100 : 4'b0011;
        dec_wdata    = {2{ex_wdata[15:0]}};
        dec_misalign = ex_addr[0];
      end
      default: begin
        dec_be       = 4'b1111;
        dec_wdata    = ex_wdata;
        dec_misalign = (ex_addr[1:0] != 2'b00);
      end
    endcase
  end

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  always_comb begin
    case (addr_q[1:0])
      2'b00:   ld_byte = dmem_rdata[7:0];
      2'b01:   ld_byte = dmem_rdata[15:8];
      2'b10:   ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3_q)
      3'd0:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
      3'd4:    ld_data = {24'd0, ld_byte};
      3'd5:    ld_data = {16'd0, ld_half};
      default: ld_data = dmem_rdata;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_cnt_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      is_load_q  <= 1'b0;
      funct3_q   <= 3'd0;
      addr_q     <= 32'd0;
      rd_q       <= 5'd0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'd0;
      dmem_be    <= 4'd0;
      dmem_wdata <= 32'd0;
      wb_valid   <= 1'b0;
      wb_rd      <= 5'd0;
      wb_data    <= 32'd0;
      misalign   <= 1'b0;
      fault_addr <= 32'd0;
`ifdef LSU_TIMEOUT_EN
      bus_err    <= 1'b0;
      tmo_cnt_q  <= '0;
`endif
    end else begin
      wb_valid <= 1'b0;
      misalign <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      bus_err  <= 1'b0;
`endif
      case (state_q)
        StIdle: begin
          if (ex_valid) begin
            is_load_q <= dec_load;
            funct3_q  <= ex_funct3;
            addr_q    <= ex_addr;
            rd_q      <= ex_rd;
            if (!dec_legal) begin
              state_q <= StDone;
            end else if (dec_misalign) begin
              state_q    <= StDone;
              misalign   <= 1'b1;
              fault_addr <= ex_addr;
            end else begin
              state_q    <= StReq;
              dmem_req   <= 1'b1;
              dmem_we    <= dec_store;
              dmem_addr  <= {ex_addr[31:2], 2'b00};
              dmem_be    <= dec_be;
              dmem_wdata <= dec_wdata;
`ifdef LSU_TIMEOUT_EN
              tmo_cnt_q  <= '0;
`endif
            end
          end
        end
        StReq: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            state_q  <= StDone;
            if (is_load_q) begin
              wb_valid <= 1'b1;
              wb_rd    <= rd_q;
              wb_data  <= ld_data;
            end
`ifdef LSU_TIMEOUT_EN
          end else if (tmo_cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1)) begin
            dmem_req   <= 1'b0;
            state_q    <= StDone;
            bus_err    <= 1'b1;
            fault_addr <= addr_q;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_unit.sv
// Directed self-checking bench for lsu_unit; adds a timeout scenario when LSU_TIMEOUT_EN is set.
module tb_lsu_unit;
  logic        clk, rst_n;
  logic        ex_valid, ex_ready, ex_is_load, ex_is_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata;
  logic [4:0]  ex_rd;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        wb_valid, misalign;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, fault_addr;
`ifdef LSU_TIMEOUT_EN
  logic        bus_err;
`endif

  int checks = 0;
  int errors = 0;

  lsu_unit #(.TIMEOUT_CYCLES(4), .TIMEOUT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .ex_is_load (ex_is_load),
    .ex_is_store(ex_is_store),
    .ex_funct3  (ex_funct3),
    .ex_addr    (ex_addr),
    .ex_wdata   (ex_wdata),
    .ex_rd      (ex_rd),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_be    (dmem_be),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .misalign   (misalign),
    .fault_addr (fault_addr)
`ifdef LSU_TIMEOUT_EN
    ,
    .bus_err    (bus_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one op and return just after the accepting edge.
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    int n = 0;
    while (!ex_ready && n < 10) begin
      step();
      n++;
    end
    check("ready_before_issue", {31'd0, ex_ready}, 32'd1);
    ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st;
    ex_funct3 = f3; ex_addr = a; ex_wdata = wd; ex_rd = rd;
    step();
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
  endtask

  task automatic ack_now(input logic [31:0] rd);
    dmem_ack = 1'b1; dmem_rdata = rd;
    step();
    dmem_ack = 1'b0; dmem_rdata = 32'd0;
  endtask

  // Load with immediate ack; checks request lanes and writeback.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rdata, input logic [3:0] be, input logic [31:0] exp);
    issue(1'b1, 1'b0, f3, a, 32'd0, 5'd7);
    check({tag, "_req"}, {31'd0, dmem_req}, 32'd1);
    check({tag, "_be"}, {28'd0, dmem_be}, {28'd0, be});
    ack_now(rdata);
    check({tag, "_wbv"}, {31'd0, wb_valid}, 32'd1);
    check({tag, "_data"}, wb_data, exp);
    step();
    check({tag, "_wbv_off"}, {31'd0, wb_valid}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
    ex_funct3 = 3'd0; ex_addr = 32'd0; ex_wdata = 32'd0; ex_rd = 5'd0;
    dmem_ack = 1'b0; dmem_rdata = 32'd0;
    #2;
    check("rst_ready", {31'd0, ex_ready}, 32'd1);
    check("rst_req", {31'd0, dmem_req}, 32'd0);
    check("rst_wbv", {31'd0, wb_valid}, 32'd0);
    check("rst_mis", {31'd0, misalign}, 32'd0);
    check("rst_be", {28'd0, dmem_be}, 32'd0);
    check("rst_fault", fault_addr, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // LW aligned, same-cycle ack
    issue(1'b1, 1'b0, 3'd2, 32'h100, 32'd0, 5'd9);
    check("lw_req", {31'd0, dmem_req}, 32'd1);
    check("lw_we", {31'd0, dmem_we}, 32'd0);
    check("lw_be", {28'd0, dmem_be}, 32'hF);
    check("lw_addr", dmem_addr, 32'h100);
    check("lw_busy", {31'd0, ex_ready}, 32'd0);
    ack_now(32'hDEADBEEF);
    check("lw_wbv", {31'd0, wb_valid}, 32'd1);
    check("lw_data", wb_data, 32'hDEADBEEF);
    check("lw_rd", {27'd0, wb_rd}, 32'd9);
    check("lw_req_off", {31'd0, dmem_req}, 32'd0);
    check("lw_ready_lo", {31'd0, ex_ready}, 32'd0);
    step();
    check("lw_wbv_off", {31'd0, wb_valid}, 32'd0);
    check("lw_ready_hi", {31'd0, ex_ready}, 32'd1);

    do_load("lb",  3'd0, 32'h103, 32'h80112233, 4'b1000, 32'hFFFFFF80);
    do_load("lbu", 3'd4, 32'h103, 32'h80112233, 4'b1000, 32'h00000080);
    do_load("lh",  3'd1, 32'h102, 32'h80112233, 4'b1100, 32'hFFFF8011);
    do_load("lhu", 3'd5, 32'h100, 32'h80112233, 4'b0011, 32'h00002233);
    do_load("lb1", 3'd0, 32'h101, 32'h80112233, 4'b0010, 32'h00000022);

    // SH with ack delayed 3 cycles: request held 4 cycles
    issue(1'b0, 1'b1, 3'd1, 32'h202, 32'h1234ABCD, 5'd0);
    for (int i = 0; i < 4; i++) begin
      check("sh_req", {31'd0, dmem_req}, 32'd1);
      check("sh_we", {31'd0, dmem_we}, 32'd1);
      check("sh_addr", dmem_addr, 32'h200);
      check("sh_be", {28'd0, dmem_be}, 32'hC);
      check("sh_wdata", dmem_wdata, 32'hABCDABCD);
      if (i < 3) step();
    end
    ack_now(32'h0);
    check("sh_req_off", {31'd0, dmem_req}, 32'd0);
    check("sh_no_wb", {31'd0, wb_valid}, 32'd0);
    step();
    check("sh_ready", {31'd0, ex_ready}, 32'd1);

    // SB lane replication
    issue(1'b0, 1'b1, 3'd0, 32'h201, 32'h000000EF, 5'd0);
    check("sb_be", {28'd0, dmem_be}, 32'h2);
    check("sb_wdata", dmem_wdata, 32'hEFEFEFEF);
    ack_now(32'h0);
    step();

    // Misaligned LW
    issue(1'b1, 1'b0, 3'd2, 32'h102, 32'd0, 5'd3);
    check("mis_req", {31'd0, dmem_req}, 32'd0);
    check("mis_pulse", {31'd0, misalign}, 32'd1);
    check("mis_fault", fault_addr, 32'h102);
    check("mis_ready_lo", {31'd0, ex_ready}, 32'd0);
    step();
    check("mis_pulse_off", {31'd0, misalign}, 32'd0);
    check("mis_ready_hi", {31'd0, ex_ready}, 32'd1);

    // Illegal load funct3 is a no-op
    issue(1'b1, 1'b0, 3'd3, 32'h100, 32'd0, 5'd3);
    check("nop_req", {31'd0, dmem_req}, 32'd0);
    check("nop_mis", {31'd0, misalign}, 32'd0);
    check("nop_wbv", {31'd0, wb_valid}, 32'd0);
    step();
    check("nop_ready", {31'd0, ex_ready}, 32'd1);

    // Both load and store set: treated as load
    issue(1'b1, 1'b1, 3'd2, 32'h104, 32'h55555555, 5'd4);
    check("both_we", {31'd0, dmem_we}, 32'd0);
    ack_now(32'h0BADF00D);
    check("both_wbv", {31'd0, wb_valid}, 32'd1);
    check("both_data", wb_data, 32'h0BADF00D);
    step();

    // Stray ack while idle is ignored
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    check("idle_ack_wbv", {31'd0, wb_valid}, 32'd0);
    check("idle_ack_ready", {31'd0, ex_ready}, 32'd1);

    // Reset in REQ
    issue(1'b1, 1'b0, 3'd2, 32'h108, 32'd0, 5'd5);
    check("rstreq_req", {31'd0, dmem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstreq_req_off", {31'd0, dmem_req}, 32'd0);
    check("rstreq_ready", {31'd0, ex_ready}, 32'd1);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("rstreq_no_wb", {31'd0, wb_valid}, 32'd0);
      step();
    end

`ifdef LSU_TIMEOUT_EN
    issue(1'b1, 1'b0, 3'd2, 32'h300, 32'd0, 5'd6);
    for (int i = 0; i < 4; i++) begin
      check("tmo_req", {31'd0, dmem_req}, 32'd1);
      step();
    end
    check("tmo_req_off", {31'd0, dmem_req}, 32'd0);
    check("tmo_err", {31'd0, bus_err}, 32'd1);
    check("tmo_fault", fault_addr, 32'h300);
    check("tmo_no_wb", {31'd0, wb_valid}, 32'd0);
    step();
    check("tmo_err_off", {31'd0, bus_err}, 32'd0);
    check("tmo_ready", {31'd0, ex_ready}, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
